// File: rtl/i2s_audio_tx.sv
// I2S transmitter: serialises 16-bit stereo PCM with BCK/LRCK derived from clk by a fractional accumulator.
// Optional macro I2S_LEFT_JUSTIFIED_EN selects left-justified framing instead of standard Philips I2S.
module i2s_audio_tx #(
   parameter int unsigned CLK_RATE    = 32'd28636360,
   parameter int unsigned SAMPLE_RATE = 32'd48000,
   parameter bit          SIGNED_IN   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] left_in,
   input  logic [15:0] right_in,
   input  logic        in_strobe,
   output logic        sample_req,
   output logic        overrun,
   output logic        I2S_BCK,
   output logic        I2S_LRCK,
   output logic        I2S_DATA
);

   localparam logic [32:0] INC_C  = 33'(64'd128 * 64'(SAMPLE_RATE));
   localparam logic [32:0] RATE_C = 33'(CLK_RATE);

   // Each BCK half must span at least two clk cycles.
   if (64'(CLK_RATE) < 64'd256 * 64'(SAMPLE_RATE)) begin : g_rate_check
      $error("i2s_audio_tx: CLK_RATE must be >= 256*SAMPLE_RATE");
   end

   logic [31:0] acc_r;
   logic        bck_r;
   logic [5:0]  bit_cnt_r;
   logic [15:0] shadow_l_r;
   logic [15:0] shadow_r_r;
   logic [15:0] frame_l_r;
   logic [15:0] frame_r_r;
   logic        pending_r;
   logic        overrun_r;
   logic        sample_req_r;
   logic        lrck_r;
   logic        data_r;

   logic [32:0] sum_s;
   logic [31:0] acc_nxt_s;
   logic        tick_s;
   logic        fall_tick_s;
   logic        frame_start_s;
   logic [5:0]  cnt_nxt_s;
   logic [4:0]  slot_s;
   logic [3:0]  idx_s;
   logic [15:0] load_l_s;
   logic [15:0] load_r_s;
   logic [15:0] frame_l_nxt_s;
   logic [15:0] frame_r_nxt_s;
   logic [15:0] word_s;
   logic        data_nxt_s;

   // Fractional accumulator producing the half-bit tick.
   always_comb begin
      sum_s     = {1'b0, acc_r} + INC_C;
      acc_nxt_s = 32'(sum_s);
      tick_s    = 1'b0;
      if (sum_s >= RATE_C) begin
         acc_nxt_s = 32'(sum_s - RATE_C);
         tick_s    = 1'b1;
      end else begin
         acc_nxt_s = 32'(sum_s);
         tick_s    = 1'b0;
      end
      fall_tick_s   = tick_s & bck_r;
      cnt_nxt_s     = bit_cnt_r + 6'd1;
      frame_start_s = fall_tick_s & (bit_cnt_r == 6'd63);
   end

   // Frame word selection; the new frame's word is already visible on the wrap tick.
   always_comb begin
      load_l_s = shadow_l_r;
      load_r_s = shadow_r_r;
      if (SIGNED_IN) begin
         load_l_s = shadow_l_r;
         load_r_s = shadow_r_r;
      end else begin
         load_l_s = {~shadow_l_r[15], shadow_l_r[14:0]};
         load_r_s = {~shadow_r_r[15], shadow_r_r[14:0]};
      end
      frame_l_nxt_s = frame_l_r;
      frame_r_nxt_s = frame_r_r;
      if (frame_start_s) begin
         frame_l_nxt_s = load_l_s;
         frame_r_nxt_s = load_r_s;
      end else begin
         frame_l_nxt_s = frame_l_r;
         frame_r_nxt_s = frame_r_r;
      end
      word_s = frame_l_nxt_s;
      if (cnt_nxt_s[5]) begin
         word_s = frame_r_nxt_s;
      end else begin
         word_s = frame_l_nxt_s;
      end
   end

   // Serial bit for the slot that becomes current on the next falling tick.
   always_comb begin
      slot_s     = cnt_nxt_s[4:0];
      idx_s      = 4'd0;
      data_nxt_s = 1'b0;
`ifdef I2S_LEFT_JUSTIFIED_EN
      if (slot_s < 5'd16) begin
         idx_s      = 4'(5'd15 - slot_s);
         data_nxt_s = word_s[idx_s];
      end else begin
         idx_s      = 4'd0;
         data_nxt_s = 1'b0;
      end
`else
      if ((slot_s >= 5'd1) && (slot_s <= 5'd16)) begin
         idx_s      = 4'(5'd16 - slot_s);
         data_nxt_s = word_s[idx_s];
      end else begin
         idx_s      = 4'd0;
         data_nxt_s = 1'b0;
      end
`endif
   end

   // Bit clock, bit counter and serial outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_r     <= 32'd0;
         bck_r     <= 1'b0;
         bit_cnt_r <= 6'd0;
         lrck_r    <= 1'b0;
         data_r    <= 1'b0;
      end else begin
         acc_r <= acc_nxt_s;
         if (tick_s) begin
            bck_r <= ~bck_r;
         end
         if (fall_tick_s) begin
            bit_cnt_r <= cnt_nxt_s;
            lrck_r    <= cnt_nxt_s[5];
            data_r    <= data_nxt_s;
         end
      end
   end

   // Shadow capture, frame load and handshake flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_l_r   <= 16'd0;
         shadow_r_r   <= 16'd0;
         frame_l_r    <= 16'd0;
         frame_r_r    <= 16'd0;
         pending_r    <= 1'b0;
         overrun_r    <= 1'b0;
         sample_req_r <= 1'b0;
      end else begin
         if (in_strobe) begin
            shadow_l_r <= left_in;
            shadow_r_r <= right_in;
         end
         frame_l_r    <= frame_l_nxt_s;
         frame_r_r    <= frame_r_nxt_s;
         sample_req_r <= frame_start_s;
         pending_r    <= in_strobe | (pending_r & ~frame_start_s);
         // A strobe landing on the frame start is not an overrun: the old shadow is consumed.
         if (in_strobe && pending_r && !frame_start_s) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign sample_req = sample_req_r;
   assign overrun    = overrun_r;
   assign I2S_BCK    = bck_r;
   assign I2S_LRCK   = lrck_r;
   assign I2S_DATA   = data_r;

endmodule
